// File: rtl/alu_multdiv.sv
// Multicycle signed multiply/divide beside the ALU: radix-2 shift-add multiply,
// restoring divide, both on magnitudes with the result sign applied at the end.
//   state | meaning
//   IDLE  | waiting for ctrl_mult / ctrl_div
//   MULT  | one shift-add iteration per edge, then sign fix-up
//   DIV   | one restoring-divide iteration per edge, then sign fix-up
//   DONE  | out/exception valid, ready pulse
module alu_multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    output logic [WIDTH-1:0] out,
    output logic             exception,
    output logic             ready,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             sign;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opb;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic               mul_ovf;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH-1:0]   quo_s;
    logic               div_zero;

    always_comb begin
        mag_a    = A[WIDTH-1] ? -A : A;
        mag_b    = B[WIDTH-1] ? -B : B;
        mul_sum  = acc_hi + {1'b0, opb};
        prod     = {acc_hi[WIDTH-1:0], acc_lo};
        prod_s   = sign ? -prod : prod;
        // product fits in WIDTH bits only if its top WIDTH+1 bits are a sign extension
        mul_ovf  = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
        rem_sh   = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        diff     = {1'b0, rem_sh} - {2'b00, opb};
        quo_s    = sign ? -acc_lo : acc_lo;
        div_zero = (opb == '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sign      <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opb       <= '0;
            out       <= '0;
            exception <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (ctrl_mult || ctrl_div) begin
                state  <= ctrl_mult ? MULT : DIV;
                busy   <= 1'b1;
                cnt    <= '0;
                sign   <= A[WIDTH-1] ^ B[WIDTH-1];
                acc_hi <= '0;
                // multiply keeps the multiplier in acc_lo, divide keeps the dividend there
                acc_lo <= ctrl_mult ? mag_b : mag_a;
                opb    <= ctrl_mult ? mag_a : mag_b;
            end else begin
                case (state)
                    IDLE: ;
                    MULT: begin
                        if (cnt != CNT_LAST) begin
                            if (acc_lo[0]) begin
                                acc_hi <= {1'b0, mul_sum[WIDTH:1]};
                                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                            end else begin
                                acc_hi <= {1'b0, acc_hi[WIDTH:1]};
                                acc_lo <= {acc_hi[0], acc_lo[WIDTH-1:1]};
                            end
                            cnt <= cnt + 1'b1;
                        end else begin
                            out       <= prod_s[WIDTH-1:0];
                            exception <= mul_ovf;
                            ready     <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end
                    end
                    DIV: begin
                        if (cnt != CNT_LAST) begin
                            if (div_zero) begin
                                cnt <= CNT_LAST;
                            end else begin
                                if (!diff[WIDTH+1]) begin
                                    acc_hi <= diff[WIDTH:0];
                                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                                end else begin
                                    acc_hi <= rem_sh;
                                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                                end
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            if (div_zero) begin
                                out       <= '0;
                                exception <= 1'b1;
                            end else begin
                                out       <= quo_s;
                                // only a positive quotient of magnitude 2^(W-1) overflows
                                exception <= !sign && acc_lo[WIDTH-1];
                            end
                            ready <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_multdiv.sv
// Bench for alu_multdiv: directed cases plus random operands checked against
// a plain-arithmetic reference model.
module tb_alu_multdiv;

    logic        clock;
    logic        reset_n;
    logic [31:0] A, B;
    logic        ctrl_mult, ctrl_div;
    logic [31:0] out;
    logic        exception, ready, busy;

    int checks = 0;
    int errors = 0;

    alu_multdiv #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .A(A), .B(B),
        .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .out(out), .exception(exception), .ready(ready), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit m, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eo, output logic ex, output int lat);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lat = 33;
        if (m) begin
            r  = sa * sb;
            eo = r[31:0];
            ex = (r != longint'($signed(eo)));
        end else if (sb == 0) begin
            eo  = 32'h0;
            ex  = 1'b1;
            lat = 2;
        end else begin
            r  = sa / sb;
            eo = r[31:0];
            ex = (r > 64'sd2147483647);
        end
    endtask

    task automatic start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_mult = m; ctrl_div = d; A = a; B = b;
        @(posedge clock);
        #1;
        ctrl_mult = 1'b0; ctrl_div = 1'b0;
        A = $urandom; B = $urandom;
    endtask

    task automatic wait_ready(output int edges);
        edges = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            edges++;
            if (ready) break;
        end
    endtask

    task automatic run_op(input string tag, input bit m, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eo;
        logic ex;
        int lat, edges;
        model(m, a, b, eo, ex, lat);
        start(m, !m, a, b);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        wait_ready(edges);
        chk({tag, "_lat"}, edges, lat);
        chk({tag, "_out"}, out, eo);
        chk({tag, "_exc"}, {31'b0, exception}, {31'b0, ex});
        chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
        @(posedge clock);
        #1;
        chk({tag, "_ready_low"}, {31'b0, ready}, 32'd0);
    endtask

    initial begin
        int edges;
        logic [31:0] ra, rb;
        bit rm;
        reset_n = 1'b0; ctrl_mult = 1'b0; ctrl_div = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out", out, 32'h0);
        chk("rst_flags", {28'b0, exception, ready, busy, 1'b0}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("m6x7", 1'b1, 32'd6, 32'd7);
        run_op("mneg", 1'b1, 32'hFFFFFFFD, 32'd5);
        run_op("movf", 1'b1, 32'h00010000, 32'h00010000);
        run_op("mmin", 1'b1, 32'h80000000, 32'h00000001);
        run_op("d100", 1'b0, 32'd100, 32'd7);
        run_op("dneg", 1'b0, 32'hFFFFFF9C, 32'd7);
        run_op("dovf", 1'b0, 32'h80000000, 32'hFFFFFFFF);
        run_op("dmin1", 1'b0, 32'h80000000, 32'h00000001);
        run_op("dz", 1'b0, 32'd5, 32'd0);

        repeat (5) @(posedge clock);
        #1;
        chk("dz_hold_out", out, 32'h0);
        chk("dz_hold_exc", {31'b0, exception}, 32'd1);
        start(1'b1, 1'b0, 32'd6, 32'd7);
        repeat (5) @(posedge clock);
        #1;
        chk("hold_mid_op_out", out, 32'h0);
        chk("hold_mid_op_exc", {31'b0, exception}, 32'd1);
        wait_ready(edges);
        chk("hold_then_out", out, 32'd42);

        // abort a multiply at iteration 10 with a divide
        start(1'b1, 1'b0, 32'd6, 32'd7);
        repeat (9) @(posedge clock);
        start(1'b0, 1'b1, 32'd9, 32'd3);
        wait_ready(edges);
        chk("abort_lat", edges, 33);
        chk("abort_out", out, 32'd3);
        start(1'b1, 1'b1, 32'd2, 32'd3);
        wait_ready(edges);
        chk("both_lat", edges, 33);
        chk("both_out", out, 32'd6);

        // reset mid-multiply
        start(1'b1, 1'b0, 32'hFFFFFFFF, 32'd3);
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrst_out", out, 32'h0);
        chk("midrst_flags", {28'b0, exception, ready, busy, 1'b0}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        run_op("post_rst", 1'b1, 32'd6, 32'd7);

        for (int i = 0; i < 24; i++) begin
            rm = $urandom_range(0, 1) == 1;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: begin ra = $urandom_range(0, 2000) - 1000; rb = $urandom_range(0, 60) - 30; end
                1: ra = ra >>> $urandom_range(0, 31);
                2: rb = rb >>> $urandom_range(8, 31);
                default: ;
            endcase
            run_op("rand", rm, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
